axi_lite_master: RTL and testbench
==================================

// Module: axi_lite_master
// PURPOSE
//  Single-outstanding AXI4-Lite initiator; peer of MMIO slaves such as the PLIC and UART.
//  Converts a simple req/resp handshake from the core's MMIO path into one AXI-Lite
//  read (AR+R) or write (AW+W+B) transaction and returns data or error status.
//  One transaction in flight; next request accepted only after response consumed.
// PARAMETERS
//  PROT  3'b000  value driven on axi_arprot/axi_awprot (unprivileged, secure, data)
// PORTS
//  clk          in   1   clock
//  rstn         in   1   asynchronous active-low reset
//  req_valid    in   1   request present
//  req_ready    out  1   block can accept request (IDLE only)
//  req_we       in   1   1=write, 0=read
//  req_addr     in   32  byte address
//  req_wdata    in   32  write data
//  req_wstrb    in   4   write byte strobes
//  resp_valid   out  1   response present
//  resp_ready   in   1   consumer takes response
//  resp_rdata   out  32  read data (0 for writes)
//  resp_err     out  1   rresp/bresp[1] of completed transaction (SLVERR/DECERR)
//  axi_araddr/arvalid/arprot out 32/1/3; axi_arready in 1
//  axi_rdata in 32; axi_rresp in 2; axi_rvalid in 1; axi_rready out 1
//  axi_awaddr/awvalid/awprot out 32/1/3; axi_awready in 1
//  axi_wdata out 32; axi_wstrb out 4; axi_wvalid out 1; axi_wready in 1
//  axi_bresp in 2; axi_bvalid in 1; axi_bready out 1
// BEHAVIOUR
//  All outputs registered. Reset (async, rstn=0): state=IDLE, req_ready=1, every
//   valid/ready out=0, addr/data/strb/rdata=0, resp_err=0; in-flight txn abandoned.
//  States: IDLE, RD_ADDR, RD_DATA, WR, WR_RESP, RESP.
//  IDLE: on req_valid&&req_ready latch addr/wdata/wstrb; req_ready<=0;
//   we=0 -> arvalid<=1, RD_ADDR; we=1 -> awvalid<=1, wvalid<=1, aw_done=w_done=0, WR.
//  RD_ADDR: hold araddr/arvalid stable until arready; then arvalid<=0, rready<=1, RD_DATA.
//  RD_DATA: on rvalid&&rready: rready<=0, resp_rdata<=rdata, resp_err<=rresp[1],
//   resp_valid<=1, RESP. rvalid before AR handshake is ignored (rready low).
//  WR: AW and W handshake independently; awvalid drops on awready, wvalid on wready,
//   either order or same cycle. When both done (incl. completing this cycle):
//   bready<=1, WR_RESP.
//  WR_RESP: on bvalid&&bready: bready<=0, resp_rdata<=0, resp_err<=bresp[1],
//   resp_valid<=1, RESP.
//  RESP: hold resp_* stable until resp_ready; then resp_valid<=0, req_ready<=1, IDLE.
//   req_valid ignored outside IDLE; no request accepted in RESP-exit cycle.
//  Min latency, zero-wait slave: read req accept (cycle 0) -> arvalid c1 -> rready c2
//   -> resp_valid c3 (if rvalid at c2). Write: awvalid/wvalid c1 -> bready c2 -> resp c3.
//  rresp/bresp OKAY and EXOKAY -> resp_err=0. No timeout: waits on slave indefinitely.
// TESTING
//  T1 read 0x1000, slave arready c1, rvalid c2 rdata=0x400 OKAY -> resp_valid c3,
//     resp_rdata=0x400, resp_err=0; req_ready low c1..c3, high after resp_ready.
//  T2 write 0x2080 wdata=0x402 wstrb=0xF, wready 3 cycles before awready -> wvalid drops
//     first, awvalid held; bready only after both; bresp=OKAY -> resp_err=0.
//  T3 write 0xDEAD0 -> slave bresp=2'b10 -> resp_err=1, resp_rdata=0.
//  T4 read with arready delayed 5 cycles, slave asserts rvalid early -> arvalid/araddr
//     stable 5 cycles; R not accepted until rready; correct rdata returned.
//  T5 resp_ready held low 4 cycles, req_valid high with new req -> resp_* stable, new
//     req accepted only after return to IDLE; back-to-back reads both complete.
//  T6 rstn low mid-WR (awvalid=1) -> same-cycle all valids 0, req_ready=1, IDLE.

Source files
------------

// File: rtl/axi_lite_master_if.sv
// axi_lite_master_if: AXI4-Lite read/write channel bundle between an initiator and a slave
interface axi_lite_master_if;
  logic [31:0] araddr;
  logic        arvalid;
  logic [2:0]  arprot;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic [2:0]  awprot;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  modport master (
    output araddr, arvalid, arprot, rready, awaddr, awvalid, awprot, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
  modport slave (
    input  araddr, arvalid, arprot, rready, awaddr, awvalid, awprot, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/axi_lite_master.sv
// axi_lite_master: single-outstanding AXI4-Lite initiator bridging a req/resp MMIO handshake
module axi_lite_master #(
  parameter logic [2:0] PROT = 3'b000
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [31:0]         req_addr,
  input  logic [31:0]         req_wdata,
  input  logic [3:0]          req_wstrb,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [31:0]         resp_rdata,
  output logic                resp_err,
  axi_lite_master_if.master   axi
);
  localparam logic [2:0] IDLE = 3'd0, RD_ADDR = 3'd1, RD_DATA = 3'd2, WR = 3'd3, WR_RESP = 3'd4, RESP = 3'd5;
  logic [2:0]  state_q, state_d;
  logic        req_ready_q, req_ready_d, arvalid_q, arvalid_d, rready_q, rready_d;
  logic        awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic        resp_valid_q, resp_valid_d, err_q, err_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        unused;
  assign unused = ^{axi.rresp[0], axi.bresp[0]};
  always_comb begin
    state_d      = state_q;
    req_ready_d  = req_ready_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    bready_d     = bready_q;
    resp_valid_d = resp_valid_q;
    err_d        = err_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    rdata_d      = rdata_q;
    case (state_q)
      IDLE: if (req_valid && req_ready_q) begin
        addr_d      = req_addr;
        wdata_d     = req_wdata;
        wstrb_d     = req_wstrb;
        req_ready_d = 1'b0;
        arvalid_d   = !req_we;
        awvalid_d   = req_we;
        wvalid_d    = req_we;
        state_d     = req_we ? WR : RD_ADDR;
      end
      RD_ADDR: if (axi.arready) begin
        arvalid_d = 1'b0;
        rready_d  = 1'b1;
        state_d   = RD_DATA;
      end
      RD_DATA: if (axi.rvalid && rready_q) begin
        rready_d     = 1'b0;
        rdata_d      = axi.rdata;
        err_d        = axi.rresp[1];
        resp_valid_d = 1'b1;
        state_d      = RESP;
      end
      // AW and W retire independently; the pending flags are the valids themselves
      WR: begin
        awvalid_d = awvalid_q && !axi.awready;
        wvalid_d  = wvalid_q && !axi.wready;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end
      end
      WR_RESP: if (axi.bvalid && bready_q) begin
        bready_d     = 1'b0;
        rdata_d      = 32'h0;
        err_d        = axi.bresp[1];
        resp_valid_d = 1'b1;
        state_d      = RESP;
      end
      RESP: if (resp_ready) begin
        resp_valid_d = 1'b0;
        req_ready_d  = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b1;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      err_q        <= 1'b0;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      wstrb_q      <= 4'h0;
      rdata_q      <= 32'h0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      bready_q     <= bready_d;
      resp_valid_q <= resp_valid_d;
      err_q        <= err_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      rdata_q      <= rdata_d;
    end
  end
  assign req_ready   = req_ready_q;
  assign resp_valid  = resp_valid_q;
  assign resp_rdata  = rdata_q;
  assign resp_err    = err_q;
  assign axi.araddr  = addr_q;
  assign axi.arvalid = arvalid_q;
  assign axi.arprot  = PROT;
  assign axi.rready  = rready_q;
  assign axi.awaddr  = addr_q;
  assign axi.awvalid = awvalid_q;
  assign axi.awprot  = PROT;
  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = wstrb_q;
  assign axi.wvalid  = wvalid_q;
  assign axi.bready  = bready_q;
endmodule

// File: tb/tb_axi_lite_master.sv
// tb_axi_lite_master: randomized AXI-Lite slave model with a response scoreboard
module tb_axi_lite_master;
  logic clk = 0, rstn = 0;
  always #5 clk = ~clk;
  logic        req_valid = 0, req_ready, req_we = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic [3:0]  req_wstrb = 0;
  logic        resp_valid, resp_ready = 0, resp_err;
  logic [31:0] resp_rdata;
  axi_lite_master_if axi();
  axi_lite_master dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err), .axi(axi)
  );
  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] data;
    logic [1:0]  resp;
  } txn_t;
  txn_t        slq[$];
  logic [32:0] expq[$];
  int checks = 0, errors = 0;
  int dmax = 0, ar_fix = -1, da_fix = -1, dw_fix = -1, early_mode = 0;
  bit rr_rand = 0, rr_force = 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: bound expired", nm);
  endtask

  // The expected response follows directly from the slave reply chosen for this transaction
  task automatic do_req(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] st, input logic [31:0] sd, input logic [1:0] sr);
    txn_t t;
    int n;
    t = '{we, addr, wd, st, sd, sr};
    slq.push_back(t);
    expq.push_back({sr[1], we ? 32'h0 : sd});
    @(negedge clk);
    req_valid = 1; req_we = we; req_addr = addr; req_wdata = wd; req_wstrb = st;
    n = 0;
    while (!req_ready && n < 500) begin @(negedge clk); n++; end
    if (n >= 500) fail("req_accept");
    @(posedge clk);
    #1 req_valid = 0;
  endtask

  initial forever begin
    @(posedge clk);
    #2 resp_ready = rr_rand ? ($urandom % 3 != 0) : rr_force;
  end

  initial begin : monitor
    bit hold;
    logic [31:0] hd;
    logic he;
    logic [32:0] e;
    hold = 0;
    forever begin
      @(negedge clk);
      if (rstn) begin
        if (hold) begin
          chk("resp_valid_hold", {31'b0, resp_valid}, 32'd1);
          chk("resp_rdata_hold", resp_rdata, hd);
          chk("resp_err_hold", {31'b0, resp_err}, {31'b0, he});
        end
        if (resp_valid) chk("req_ready_busy", {31'b0, req_ready}, 32'd0);
        if (resp_valid && resp_ready) begin
          hold = 0;
          if (expq.size() == 0) fail("unexpected_resp");
          else begin
            e = expq.pop_front();
            chk("resp_rdata", resp_rdata, e[31:0]);
            chk("resp_err", {31'b0, resp_err}, {31'b0, e[32]});
          end
        end else begin
          hold = resp_valid; hd = resp_rdata; he = resp_err;
        end
      end
    end
  end

  initial begin : slave
    txn_t t;
    int d, da, dw, k;
    bit early;
    axi.arready = 0; axi.rvalid = 0; axi.rdata = 0; axi.rresp = 0;
    axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = 0;
    forever begin
      @(negedge clk);
      if ((axi.arvalid || axi.awvalid || axi.wvalid) && slq.size() == 0) fail("slave_queue_empty");
      else if (axi.arvalid) begin
        t = slq.pop_front();
        chk("rd_expected", {31'b0, t.we}, 32'd0);
        chk("arprot", {29'b0, axi.arprot}, 32'd0);
        early = early_mode == 1 || (early_mode == 2 && $urandom % 2 == 1);
        if (early) begin axi.rvalid = 1; axi.rdata = t.data; axi.rresp = t.resp; end
        d = ar_fix >= 0 ? ar_fix : $urandom_range(dmax, 0);
        repeat (d) begin
          chk("arvalid_hold", {31'b0, axi.arvalid}, 32'd1);
          chk("araddr_hold", axi.araddr, t.addr);
          chk("rready_before_ar", {31'b0, axi.rready}, 32'd0);
          @(negedge clk);
        end
        chk("araddr", axi.araddr, t.addr);
        axi.arready = 1;
        @(negedge clk);
        axi.arready = 0;
        if (!early) begin
          repeat ($urandom_range(dmax, 0)) @(negedge clk);
          axi.rvalid = 1; axi.rdata = t.data; axi.rresp = t.resp;
        end
        k = 0;
        while (!axi.rready && k < 100) begin @(negedge clk); k++; end
        if (k >= 100) fail("rready_wait");
        @(negedge clk);
        axi.rvalid = 0; axi.rdata = $urandom;
      end else if (axi.awvalid || axi.wvalid) begin
        t = slq.pop_front();
        chk("wr_expected", {31'b0, t.we}, 32'd1);
        chk("awaddr", axi.awaddr, t.addr);
        chk("wdata", axi.wdata, t.wdata);
        chk("wstrb", {28'b0, axi.wstrb}, {28'b0, t.strb});
        chk("awprot", {29'b0, axi.awprot}, 32'd0);
        da = da_fix >= 0 ? da_fix : $urandom_range(dmax, 0);
        dw = dw_fix >= 0 ? dw_fix : $urandom_range(dmax, 0);
        k = 0;
        while ((axi.awvalid || axi.wvalid) && k < 200) begin
          chk("bready_before_aw_w", {31'b0, axi.bready}, 32'd0);
          axi.awready = axi.awvalid && k >= da;
          axi.wready  = axi.wvalid && k >= dw;
          @(negedge clk);
          k++;
        end
        axi.awready = 0; axi.wready = 0;
        if (k >= 200) fail("aw_w_wait");
        chk("bready", {31'b0, axi.bready}, 32'd1);
        repeat ($urandom_range(dmax, 0)) @(negedge clk);
        axi.bvalid = 1; axi.bresp = t.resp;
        k = 0;
        while (!axi.bready && k < 100) begin @(negedge clk); k++; end
        if (k >= 100) fail("bready_wait");
        @(negedge clk);
        axi.bvalid = 0;
      end
    end
  end

  task automatic latency(input string nm);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!resp_valid && n < 20);
    chk(nm, n, 32'd3);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((expq.size() != 0 || !req_ready) && n < 2000) begin @(negedge clk); n++; end
    if (n >= 2000) fail("drain");
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_arvalid", {31'b0, axi.arvalid}, 32'd0);
    chk("rst_awvalid", {31'b0, axi.awvalid}, 32'd0);
    chk("rst_wvalid", {31'b0, axi.wvalid}, 32'd0);
    chk("rst_rready", {31'b0, axi.rready}, 32'd0);
    chk("rst_bready", {31'b0, axi.bready}, 32'd0);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
    chk("rst_araddr", axi.araddr, 32'h0);
    rstn = 1;
    // zero-wait slave: minimum read and write latency
    do_req(0, 32'h1000, 32'h0, 4'h0, 32'h400, 2'b00);
    latency("rd_latency");
    drain();
    do_req(1, 32'h3000, 32'h55AA, 4'h3, 32'h0, 2'b01);
    latency("wr_latency");
    drain();
    da_fix = 3; dw_fix = 0;
    do_req(1, 32'h2080, 32'h402, 4'hF, 32'h0, 2'b00);
    repeat (2) @(negedge clk);
    chk("t2_wvalid_dropped", {31'b0, axi.wvalid}, 32'd0);
    chk("t2_awvalid_held", {31'b0, axi.awvalid}, 32'd1);
    drain();
    da_fix = -1; dw_fix = -1;
    do_req(1, 32'hDEAD0, 32'h1234, 4'h5, 32'h0, 2'b10);
    drain();
    ar_fix = 5; early_mode = 1;
    do_req(0, 32'h4004, 32'h0, 4'h0, 32'hCAFE_F00D, 2'b00);
    drain();
    ar_fix = -1; early_mode = 0; rr_force = 0;
    fork
      begin
        do_req(0, 32'h5000, 32'h0, 4'h0, 32'h1111_2222, 2'b11);
        do_req(0, 32'h5004, 32'h0, 4'h0, 32'h3333_4444, 2'b00);
      end
      begin
        n = 0;
        while (!resp_valid && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) fail("t5_resp_wait");
        repeat (4) begin
          @(negedge clk);
          chk("t5_req_ready_low", {31'b0, req_ready}, 32'd0);
        end
        rr_force = 1;
      end
    join
    drain();
    dmax = 4; early_mode = 2; rr_rand = 1;
    for (int i = 0; i < 60; i++)
      do_req($urandom % 2 == 1, $urandom, $urandom, 4'($urandom), $urandom, 2'($urandom));
    drain();
    rr_rand = 0; rr_force = 1; dmax = 0; early_mode = 0;
    da_fix = 100000; dw_fix = 0;
    do_req(1, 32'h6000, 32'h77, 4'hF, 32'h0, 2'b00);
    n = 0;
    while (!axi.awvalid && n < 10) begin @(negedge clk); n++; end
    if (n >= 10) fail("t6_awvalid_wait");
    @(posedge clk);
    #2 rstn = 0;
    #1;
    chk("t6_awvalid", {31'b0, axi.awvalid}, 32'd0);
    chk("t6_wvalid", {31'b0, axi.wvalid}, 32'd0);
    chk("t6_arvalid", {31'b0, axi.arvalid}, 32'd0);
    chk("t6_bready", {31'b0, axi.bready}, 32'd0);
    chk("t6_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("t6_req_ready", {31'b0, req_ready}, 32'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    fail("watchdog");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end
endmodule
